sw_alloc_rr: RTL and testbench

//  Switch allocator for one 5-port mesh router: arbitrates the five input buffers onto the five output buffers.

---
 rtl/sw_alloc_rr.sv | 172 +++++++++++++++++
 tb/tb_sw_alloc_rr.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sw_alloc_rr.sv
// Switch allocator for a 5-port mesh router (N,E,S,W,L).
// Each output port runs its own round-robin arbiter. Every grant is gated by
// that output's obuf_rdy, and the winner drives the crossbar select.
// Copy-mode packets keep their unsent outputs in a pending mask until every
// copy has been sent. Grants and selects are combinational; pointers, pending
// masks and per-input state are registered.
module sw_alloc_rr #(
  parameter int NPORT = 5,
  parameter int SELW  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NPORT-1:0]      in_vld,
  input  logic [NPORT*5-1:0]    in_req,
  input  logic [NPORT-1:0]      in_cpy,
  input  logic [NPORT-1:0]      obuf_rdy,
  output logic [NPORT*5-1:0]    gnt,
  output logic [NPORT-1:0]      out_vld,
  output logic [NPORT*SELW-1:0] out_sel,
  output logic [NPORT-1:0]      in_done,
  output logic [NPORT-1:0]      in_busy
);

  localparam logic [0:0]      ST_IDLE   = 1'b0;
  localparam logic [0:0]      ST_ACTIVE = 1'b1;
  localparam logic [SELW-1:0] SEL_NONE  = {SELW{1'b1}};

  logic [NPORT-1:0]       state_r;   // one bit per input, ST_IDLE / ST_ACTIVE
  logic [NPORT-1:0][4:0]  pend_r;    // outputs still owed to an ACTIVE input
  logic [NPORT-1:0][2:0]  ptr_r;     // round-robin start index per output

  logic [NPORT-1:0][4:0]  eff_s;     // effective request mask per input
  logic [NPORT-1:0][4:0]  cand_s;    // candidate inputs per output
  logic [NPORT-1:0][3:0]  pick_s;    // {found, winner index} per output
  logic [NPORT-1:0][4:0]  rem_s;     // requested outputs not granted this cycle

  // Isolate the lowest set bit of a request mask (unicast picks one output).
  function automatic logic [4:0] lowest_bit(input logic [4:0] m);
    return m & (~m + 5'd1);
  endfunction

  // Round-robin search starting at ptr, increasing index mod 5.
  // The search runs from the farthest offset down, so the last match kept
  // is the one nearest to ptr.
  function automatic logic [3:0] rr_pick(input logic [4:0] cand, input logic [2:0] ptr);
    logic [3:0] res;
    logic [3:0] idx;
    res = {1'b0, 3'd7};
    for (int k = 4; k >= 0; k--) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'd5) begin
        idx = idx - 4'd5;
      end else begin
        idx = idx;
      end
      if (cand[idx[2:0]]) begin
        res = {1'b1, idx[2:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Effective request per input.
  // While reset is asserted every request is masked, so no grant leaks out.
  always_comb begin
    eff_s = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (!rst_n || !in_vld[i]) begin
        eff_s[i] = 5'd0;
      end else if (state_r[i] == ST_ACTIVE) begin
        eff_s[i] = pend_r[i];
      end else if (in_cpy[i]) begin
        eff_s[i] = in_req[5*i +: 5];
      end else begin
        eff_s[i] = lowest_bit(in_req[5*i +: 5]);
      end
    end
  end

  // Transpose the effective requests into per-output candidate sets and pick winners.
  always_comb begin
    cand_s = '0;
    pick_s = '0;
    for (int j = 0; j < NPORT; j++) begin
      for (int i = 0; i < NPORT; i++) begin
        cand_s[j][i] = eff_s[i][j];
      end
      pick_s[j] = rr_pick(cand_s[j], ptr_r[j]);
    end
  end

  // Gate the winners with output readiness and drive grants and crossbar selects.
  always_comb begin
    gnt     = '0;
    out_vld = '0;
    out_sel = '1;
    for (int j = 0; j < NPORT; j++) begin
      if (obuf_rdy[j] && pick_s[j][3]) begin
        out_vld[j]               = 1'b1;
        out_sel[SELW*j +: SELW]  = SELW'(pick_s[j][2:0]);
        for (int i = 0; i < NPORT; i++) begin
          if (pick_s[j][2:0] == 3'(i)) begin
            gnt[5*i+j] = 1'b1;
          end else begin
            gnt[5*i+j] = 1'b0;
          end
        end
      end else begin
        out_vld[j]              = 1'b0;
        out_sel[SELW*j +: SELW] = SEL_NONE;
      end
    end
  end

  // Remaining copies and completion pulse per input.
  always_comb begin
    rem_s   = '0;
    in_done = '0;
    for (int i = 0; i < NPORT; i++) begin
      rem_s[i] = eff_s[i] & ~gnt[5*i +: 5];
      if ((eff_s[i] != 5'd0) && (rem_s[i] == 5'd0)) begin
        in_done[i] = 1'b1;
      end else begin
        in_done[i] = 1'b0;
      end
    end
  end

  assign in_busy = state_r;

  // Advance the round-robin pointers. Also update each input's state and pending copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= '0;
      pend_r  <= '0;
      ptr_r   <= '0;
    end else begin
      for (int j = 0; j < NPORT; j++) begin
        if (out_vld[j]) begin
          ptr_r[j] <= (pick_s[j][2:0] == 3'd4) ? 3'd0 : pick_s[j][2:0] + 3'd1;
        end else begin
          ptr_r[j] <= ptr_r[j];
        end
      end
      for (int i = 0; i < NPORT; i++) begin
        if (eff_s[i] != 5'd0) begin
          if (rem_s[i] == 5'd0) begin
            state_r[i] <= ST_IDLE;
            pend_r[i]  <= 5'd0;
          end else if ((state_r[i] == ST_ACTIVE) || in_cpy[i]) begin
            state_r[i] <= ST_ACTIVE;
            pend_r[i]  <= rem_s[i];
          end else begin
            // Unicast that lost arbitration: re-request from in_req next cycle.
            state_r[i] <= ST_IDLE;
            pend_r[i]  <= 5'd0;
          end
        end else if ((state_r[i] == ST_ACTIVE) && !in_vld[i]) begin
          // Packet withdrawn mid copy: drop the remaining copies silently.
          state_r[i] <= ST_IDLE;
          pend_r[i]  <= 5'd0;
        end else begin
          state_r[i] <= state_r[i];
          pend_r[i]  <= pend_r[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_alloc_rr.sv
// Directed bench for sw_alloc_rr: reset, unicast, round-robin order,
// backpressure, copy-mode fan-out, abort and empty-request cases.
module tb_sw_alloc_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  in_vld;
  logic [24:0] in_req;
  logic [4:0]  in_cpy;
  logic [4:0]  obuf_rdy;
  logic [24:0] gnt;
  logic [4:0]  out_vld;
  logic [14:0] out_sel;
  logic [4:0]  in_done;
  logic [4:0]  in_busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [24:0] t3_gnt [6] = '{25'h0000010, 25'h0000200, 25'h0080000,
                              25'h0000010, 25'h0000200, 25'h0080000};
  logic [14:0] t3_sel [6] = '{15'h0FFF, 15'h1FFF, 15'h3FFF,
                              15'h0FFF, 15'h1FFF, 15'h3FFF};

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  sw_alloc_rr #(.NPORT(5), .SELW(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_req   (in_req),
    .in_cpy   (in_cpy),
    .obuf_rdy (obuf_rdy),
    .gnt      (gnt),
    .out_vld  (out_vld),
    .out_sel  (out_sel),
    .in_done  (in_done),
    .in_busy  (in_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_vld = 5'h00;
    in_req = 25'h0;
    in_cpy = 5'h00;
  endtask

  // Directed stimulus sequence.
  initial begin
    // T1: reset with every input valid
    rst_n    = 1'b0;
    in_vld   = 5'h1F;
    in_req   = {5{5'b00001}};
    in_cpy   = 5'h00;
    obuf_rdy = 5'h1F;
    #3;
    chk("t1_gnt",     32'(gnt),     32'h0);
    chk("t1_out_vld", 32'(out_vld), 32'h0);
    chk("t1_out_sel", 32'(out_sel), 32'h7FFF);
    chk("t1_in_done", 32'(in_done), 32'h0);
    chk("t1_in_busy", 32'(in_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // ptr_0 == 0 after reset: input 0 wins output 0
    chk("t1_gnt_rel",  32'(gnt),     32'h0000001);
    chk("t1_sel_rel",  32'(out_sel), 32'h7FF8);
    chk("t1_done_rel", 32'(in_done), 32'h01);

    // T2: single unicast from input 2 to output 0 (ptr_0 == 1)
    next_cycle();
    clear_inputs();
    in_vld[2]     = 1'b1;
    in_req[14:10] = 5'b00001;
    #1;
    chk("t2_gnt",     32'(gnt),     32'h0000400);
    chk("t2_out_vld", 32'(out_vld), 32'h01);
    chk("t2_out_sel", 32'(out_sel), 32'h7FFA);
    chk("t2_in_done", 32'(in_done), 32'h04);
    // ptr_0 is now 3: among inputs 0,2,4 the winner is 4
    next_cycle();
    in_vld        = 5'b10101;
    in_req        = {5'b00001, 5'b00000, 5'b00001, 5'b00000, 5'b00001};
    #1;
    chk("t2_ptr_gnt",  32'(gnt),     32'h0100000);
    chk("t2_ptr_sel",  32'(out_sel), 32'h7FFC);
    chk("t2_ptr_done", 32'(in_done), 32'h10);

    // T3: inputs 0,1,3 contend for output 4 over six cycles
    next_cycle();
    clear_inputs();
    in_vld = 5'b01011;
    in_req = {5'b00000, 5'b10000, 5'b00000, 5'b10000, 5'b10000};
    for (int c = 0; c < 6; c++) begin
      if (c != 0) next_cycle();
      #1;
      chk("t3_gnt", 32'(gnt),     32'(t3_gnt[c]));
      chk("t3_sel", 32'(out_sel), 32'(t3_sel[c]));
    end

    // T4: input 1 to output 2 under backpressure for three cycles
    next_cycle();
    clear_inputs();
    in_vld[1]   = 1'b1;
    in_req[9:5] = 5'b00100;
    obuf_rdy    = 5'b11011;
    for (int c = 0; c < 3; c++) begin
      if (c != 0) next_cycle();
      #1;
      chk("t4_bp_gnt",  32'(gnt),     32'h0);
      chk("t4_bp_vld",  32'(out_vld), 32'h0);
      chk("t4_bp_done", 32'(in_done), 32'h0);
    end
    next_cycle();
    obuf_rdy = 5'h1F;
    #1;
    chk("t4_gnt",  32'(gnt),     32'h0000080);
    chk("t4_sel",  32'(out_sel), 32'h7E7F);
    chk("t4_done", 32'(in_done), 32'h02);

    // T5: copy-mode packet from input 4 to outputs 1 and 2
    next_cycle();
    clear_inputs();
    in_vld[4]     = 1'b1;
    in_cpy[4]     = 1'b1;
    in_req[24:20] = 5'b00110;
    obuf_rdy      = 5'b00010;
    #1;
    chk("t5_c0_gnt",  32'(gnt),     32'h0200000);
    chk("t5_c0_vld",  32'(out_vld), 32'h02);
    chk("t5_c0_done", 32'(in_done), 32'h0);
    next_cycle();
    obuf_rdy      = 5'h1F;
    in_req[24:20] = 5'b11111;   // ignored while the packet is ACTIVE
    #1;
    chk("t5_c1_busy", 32'(in_busy), 32'h10);
    chk("t5_c1_gnt",  32'(gnt),     32'h0400000);
    chk("t5_c1_sel",  32'(out_sel), 32'h7F3F);
    chk("t5_c1_done", 32'(in_done), 32'h10);
    next_cycle();
    clear_inputs();
    #1;
    chk("t5_c2_busy", 32'(in_busy), 32'h0);

    // T6: copy-mode packet aborted with pend = 5'b01000
    in_vld[3]     = 1'b1;
    in_cpy[3]     = 1'b1;
    in_req[19:15] = 5'b01001;
    obuf_rdy      = 5'b00001;
    #1;
    chk("t6_c0_gnt", 32'(gnt),     32'h0008000);
    chk("t6_c0_sel", 32'(out_sel), 32'h7FFB);
    next_cycle();
    clear_inputs();
    obuf_rdy = 5'h1F;
    #1;
    chk("t6_c1_busy", 32'(in_busy), 32'h08);
    chk("t6_c1_gnt",  32'(gnt),     32'h0);
    chk("t6_c1_done", 32'(in_done), 32'h0);
    next_cycle();
    in_vld[3]     = 1'b1;
    in_req[19:15] = 5'b00100;
    #1;
    chk("t6_c2_busy", 32'(in_busy), 32'h0);
    chk("t6_c2_gnt",  32'(gnt),     32'h0020000);
    chk("t6_c2_done", 32'(in_done), 32'h08);

    // Valid input with an empty request mask is ignored
    next_cycle();
    clear_inputs();
    in_vld[0] = 1'b1;
    #1;
    chk("zero_req_gnt",  32'(gnt),     32'h0);
    chk("zero_req_vld",  32'(out_vld), 32'h0);
    chk("zero_req_done", 32'(in_done), 32'h0);

    next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
